// File: rtl/aoi21_pipe_pkg.sv
// Shared types and the per-lane compound gate function for the AOI21 pipeline bank.
package aoi21_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_AOI21 = 2'b00,
    MODE_OAI21 = 2'b01,
    MODE_AO21  = 2'b10,
    MODE_OA21  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  function automatic logic lane_fn(mode_e mode, logic a, logic b1, logic b2);
    logic res;
    case (mode)
      MODE_AOI21: res = ~(a | (b1 & b2));
      MODE_OAI21: res = ~(a & (b1 | b2));
      MODE_AO21:  res =  (a | (b1 & b2));
      default:    res =  (a & (b1 | b2));
    endcase
    return res;
  endfunction

endpackage

// File: rtl/aoi21_pipe_bank_if.sv
// Producer/consumer handshake bundle of the AOI21 pipeline bank.
interface aoi21_pipe_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B1;
  logic [WIDTH-1:0] B2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ZN;
  logic             zn_par;
  logic [CNT_W-1:0] xfer_cnt;

  modport master (
    output in_valid, mode, A, B1, B2, out_ready,
    input  in_ready, out_valid, ZN, zn_par, xfer_cnt
  );

  modport slave (
    input  in_valid, mode, A, B1, B2, out_ready,
    output in_ready, out_valid, ZN, zn_par, xfer_cnt
  );
endinterface

// File: rtl/aoi21_pipe_slot.sv
// One buffer entry: a load-enabled register cleared asynchronously by RN.
module aoi21_pipe_slot #(
  parameter int DW = 8
) (
  input  logic          CK,
  input  logic          RN,
  input  logic          load,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/aoi21_pipe_bank.sv
// WIDTH-lane selectable AOI21/OAI21/AO21/OA21 bank feeding a 2-entry valid/ready buffer.
// Optional parity storage is enabled by `define AOI21_PIPE_PARITY_EN.
module aoi21_pipe_bank
  import aoi21_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic              CK,
  input logic              RN,
  aoi21_pipe_bank_if.slave bus
);

`ifdef AOI21_PIPE_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  occ_e             occ_reg;
  logic [CNT_W-1:0] xfer_cnt_reg;
  logic [WIDTH-1:0] result;
  logic [DW-1:0]    entry_new;
  logic [DW-1:0]    head_q;
  logic [DW-1:0]    tail_q;
  logic [DW-1:0]    head_d;
  logic             head_load;
  logic             tail_load;
  logic             push;
  logic             pop;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      assign result[gi] = lane_fn(mode_e'(bus.mode), bus.A[gi], bus.B1[gi], bus.B2[gi]);
    end
  endgenerate

`ifdef AOI21_PIPE_PARITY_EN
  assign entry_new  = {^result, result};
  assign bus.zn_par = head_q[WIDTH];
`else
  assign entry_new  = result;
  assign bus.zn_par = 1'b0;
`endif

  // RN gates in_ready directly so nothing is accepted while reset is held.
  assign bus.in_ready  = RN && (occ_reg != OCC_TWO);
  assign bus.out_valid = (occ_reg != OCC_EMPTY);
  assign bus.ZN        = head_q[WIDTH-1:0];
  assign bus.xfer_cnt  = xfer_cnt_reg;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Head takes the new word when it becomes (or stays) the only entry; otherwise tail moves up.
  assign head_load = ((occ_reg == OCC_EMPTY) && push) ||
                     ((occ_reg == OCC_ONE) && push && pop) ||
                     ((occ_reg == OCC_TWO) && pop);
  assign head_d    = (occ_reg == OCC_TWO) ? tail_q : entry_new;
  assign tail_load = (occ_reg == OCC_ONE) && push && !pop;

  aoi21_pipe_slot #(.DW(DW)) u_head (
    .CK   (CK),
    .RN   (RN),
    .load (head_load),
    .d    (head_d),
    .q    (head_q)
  );

  aoi21_pipe_slot #(.DW(DW)) u_tail (
    .CK   (CK),
    .RN   (RN),
    .load (tail_load),
    .d    (entry_new),
    .q    (tail_q)
  );

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      occ_reg      <= OCC_EMPTY;
      xfer_cnt_reg <= '0;
    end else begin
      if (pop && (xfer_cnt_reg != {CNT_W{1'b1}})) begin
        xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
      end
      case (occ_reg)
        OCC_EMPTY: if (push) occ_reg <= OCC_ONE;
        OCC_ONE: begin
          if (push && !pop)      occ_reg <= OCC_TWO;
          else if (!push && pop) occ_reg <= OCC_EMPTY;
        end
        OCC_TWO:   if (pop) occ_reg <= OCC_ONE;
        default:   occ_reg <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_aoi21_pipe_bank.sv
// Directed, table-driven bench for aoi21_pipe_bank (WIDTH=8); parity checks follow AOI21_PIPE_PARITY_EN.
module tb_aoi21_pipe_bank;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  typedef struct {
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] b2;
    logic [WIDTH-1:0] exp_zn;
  } vec_t;

  logic CK;
  logic RN;
  int   total;
  int   bad;
  vec_t vecs [8];

  aoi21_pipe_bank_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  aoi21_pipe_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CK  (CK),
    .RN  (RN),
    .bus (bus)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_par(input string name, input logic [WIDTH-1:0] exp_zn);
`ifdef AOI21_PIPE_PARITY_EN
    check(name, 64'(bus.zn_par), 64'(^exp_zn));
`else
    check(name, 64'(bus.zn_par), 64'd0);
`endif
  endtask

  task automatic apply_reset();
    @(negedge CK);
    RN = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("rst_in_ready_low", 64'(bus.in_ready), 64'd0);
    repeat (2) @(negedge CK);
    RN = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] a,
                       input logic [7:0] b1, input logic [7:0] b2, input logic ordy);
    bus.in_valid  = v;
    bus.mode      = m;
    bus.A         = a;
    bus.B1        = b1;
    bus.B2        = b2;
    bus.out_ready = ordy;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RN    = 1'b1;
    drive(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0);

    // Hand-computed: AOI21 ~(A|B1&B2), OAI21 ~(A&(B1|B2)), AO21 A|B1&B2, OA21 A&(B1|B2).
    vecs[0] = '{2'b00, 8'h0F, 8'hF0, 8'hFF, 8'h00};
    vecs[1] = '{2'b00, 8'hA5, 8'h3C, 8'h0F, 8'h52};
    vecs[2] = '{2'b01, 8'hA5, 8'h3C, 8'h0F, 8'hDA};
    vecs[3] = '{2'b10, 8'hA5, 8'h3C, 8'h0F, 8'hAD};
    vecs[4] = '{2'b11, 8'hA5, 8'h3C, 8'h0F, 8'h25};
    vecs[5] = '{2'b01, 8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[6] = '{2'b10, 8'h00, 8'hAA, 8'h0F, 8'h0A};
    vecs[7] = '{2'b11, 8'hFF, 8'h0F, 8'hF0, 8'hFF};

    // Reset state
    apply_reset();
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_zn", 64'(bus.ZN), 64'h00);
    check("reset_xfer_cnt", 64'(bus.xfer_cnt), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_zn_par", 64'(bus.zn_par), 64'd0);

    // Single words through the table, consumer always ready
    for (int i = 0; i < 8; i++) begin
      @(negedge CK);
      drive(1'b1, vecs[i].mode, vecs[i].a, vecs[i].b1, vecs[i].b2, 1'b1);
      @(negedge CK);
      bus.in_valid = 1'b0;
      check($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("vec%0d_zn", i), 64'(bus.ZN), 64'(vecs[i].exp_zn));
      check_par($sformatf("vec%0d_par", i), vecs[i].exp_zn);
      $display("vec %0d mode=%0b A=%h B1=%h B2=%h ZN=%h", i, vecs[i].mode, vecs[i].a,
               vecs[i].b1, vecs[i].b2, bus.ZN);
    end
    @(negedge CK);
    check("table_drained", 64'(bus.out_valid), 64'd0);
    check("table_xfer_cnt", 64'(bus.xfer_cnt), 64'd8);

    // Backpressure: third word must be refused while full
    apply_reset();
    @(negedge CK);
    drive(1'b1, 2'b10, 8'h11, 8'h00, 8'h00, 1'b0);
    @(negedge CK);
    check("bp_in_ready_one", 64'(bus.in_ready), 64'd1);
    check("bp_zn_w1", 64'(bus.ZN), 64'h11);
    drive(1'b1, 2'b10, 8'h22, 8'h00, 8'h00, 1'b0);
    @(negedge CK);
    check("bp_in_ready_full", 64'(bus.in_ready), 64'd0);
    check("bp_zn_hold", 64'(bus.ZN), 64'h11);
    drive(1'b1, 2'b10, 8'h33, 8'h00, 8'h00, 1'b0);
    @(negedge CK);
    check("bp_in_ready_still_full", 64'(bus.in_ready), 64'd0);
    check("bp_zn_stable", 64'(bus.ZN), 64'h11);
    check_par("bp_par_stable", 8'h11);
    drive(1'b0, 2'b10, 8'h00, 8'h00, 8'h00, 1'b1);
    @(negedge CK);
    check("bp_out_w2_valid", 64'(bus.out_valid), 64'd1);
    check("bp_out_w2", 64'(bus.ZN), 64'h22);
    check_par("bp_par_w2", 8'h22);
    check("bp_in_ready_free", 64'(bus.in_ready), 64'd1);
    @(negedge CK);
    check("bp_empty", 64'(bus.out_valid), 64'd0);
    check("bp_xfer_cnt", 64'(bus.xfer_cnt), 64'd2);
    $display("backpressure xfer_cnt=%0d", bus.xfer_cnt);

    // Streaming: push and pop every cycle while holding one entry
    apply_reset();
    @(negedge CK);
    drive(1'b1, 2'b10, 8'd0, 8'h00, 8'h00, 1'b1);
    for (int i = 1; i <= 100; i++) begin
      @(negedge CK);
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.ZN !== 8'(i - 1)) begin
        bad++;
        $display("FAIL stream_%0d: in_ready=%b out_valid=%b ZN=%h expected 1 1 %h",
                 i, bus.in_ready, bus.out_valid, bus.ZN, 8'(i - 1));
      end
      if (i < 100) bus.A = 8'(i);
      else bus.in_valid = 1'b0;
    end
    @(negedge CK);
    check("stream_xfer_cnt", 64'(bus.xfer_cnt), 64'd100);
    check("stream_empty", 64'(bus.out_valid), 64'd0);
    $display("stream xfer_cnt=%0d", bus.xfer_cnt);

    // Reset mid-operation with two entries held
    drive(1'b1, 2'b00, 8'h0F, 8'hF0, 8'h0F, 1'b0);
    @(negedge CK);
    bus.A = 8'h55;
    @(negedge CK);
    bus.in_valid = 1'b0;
    check("hold_full", 64'(bus.in_ready), 64'd0);
    check("hold_zn", 64'(bus.ZN), 64'hF0);
    #2;
    RN = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_xfer_cnt", 64'(bus.xfer_cnt), 64'd0);
    check("midrst_zn", 64'(bus.ZN), 64'h00);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    check("midrst_zn_par", 64'(bus.zn_par), 64'd0);
    @(negedge CK);
    RN = 1'b1;
    @(negedge CK);
    check("post_rst_empty", 64'(bus.out_valid), 64'd0);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
